// File: rtl/obstacle_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : obstacle_sequencer_if
// Description : Position-ROM bus and obstacle output bundle of the obstacle
//               sequencer. The master side is the sequencer; the slave side
//               supplies ROM data and consumes obstacle positions.
// Revision    : 1.0 - initial release
// ============================================================================
interface obstacle_sequencer_if;
  logic [2:0] rom_index;
  logic [9:0] rom_x0;
  logic [9:0] rom_y0;
  logic [9:0] rom_x1;
  logic [9:0] rom_y1;
  logic [9:0] obs_x0;
  logic [9:0] obs_y0;
  logic [9:0] obs_x1;
  logic [9:0] obs_y1;
  logic       obs_valid;
  logic [7:0] wave_count;

  modport master (
    output rom_index,
    input  rom_x0, rom_y0, rom_x1, rom_y1,
    output obs_x0, obs_y0, obs_x1, obs_y1,
    output obs_valid,
    output wave_count
  );

  modport slave (
    input  rom_index,
    output rom_x0, rom_y0, rom_x1, rom_y1,
    input  obs_x0, obs_y0, obs_x1, obs_y1,
    input  obs_valid,
    input  wave_count
  );
endinterface
`default_nettype wire

// File: rtl/obstacle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : obstacle_sequencer
// Description : Spawns waves of two obstacles from a pseudo-randomly chosen
//               position-ROM pattern, scrolls them down the road once per
//               frame and waits a fixed number of frames between waves.
// Revision    : 1.0 - initial release
// ============================================================================
module obstacle_sequencer #(
  parameter logic [9:0] Y_LIMIT    = 10'd480,
  parameter logic [7:0] GAP_FRAMES = 8'd30
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  input  wire logic           enable,
  input  wire logic           frame_tick,
  input  wire logic [3:0]     speed,
  obstacle_sequencer_if.master bus
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_LOAD = 2'd1;
  localparam logic [1:0] c_RUN  = 2'd2;
  localparam logic [1:0] c_GAP  = 2'd3;

  logic [1:0] r_state;
  logic [7:0] r_lfsr;
  logic [7:0] r_gap_cnt;
  logic [2:0] r_rom_index;
  logic [9:0] r_obs_x0;
  logic [9:0] r_obs_y0;
  logic [9:0] r_obs_x1;
  logic [9:0] r_obs_y1;
  logic       r_obs_valid;
  logic [7:0] r_wave_count;

  logic [2:0] w_map_idx;
  logic [9:0] w_y0_nxt;
  logic [9:0] w_y1_nxt;
  logic       w_wave_done;
  logic [7:0] w_gap_nxt;

  // Only six patterns exist; fold LFSR values 6 and 7 onto patterns 0 and 1.
  assign w_map_idx = (r_lfsr[2:0] < 3'd6) ? r_lfsr[2:0] : {2'b00, r_lfsr[0]};

  // An obstacle at or below the road edge is parked; y < Y_LIMIT <= 1008
  // guarantees the adder cannot wrap.
  assign w_y0_nxt    = (r_obs_y0 < Y_LIMIT) ? (r_obs_y0 + {6'd0, speed}) : r_obs_y0;
  assign w_y1_nxt    = (r_obs_y1 < Y_LIMIT) ? (r_obs_y1 + {6'd0, speed}) : r_obs_y1;
  assign w_wave_done = (w_y0_nxt >= Y_LIMIT) && (w_y1_nxt >= Y_LIMIT);
  assign w_gap_nxt   = r_gap_cnt + 8'd1;

  assign bus.rom_index  = r_rom_index;
  assign bus.obs_x0     = r_obs_x0;
  assign bus.obs_y0     = r_obs_y0;
  assign bus.obs_x1     = r_obs_x1;
  assign bus.obs_y1     = r_obs_y1;
  assign bus.obs_valid  = r_obs_valid;
  assign bus.wave_count = r_wave_count;

  // Free-running pattern-select LFSR, independent of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 8'h01;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  // Wave FSM: select pattern, load it, scroll it, then count off the gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_IDLE;
      r_gap_cnt    <= 8'd0;
      r_rom_index  <= 3'd0;
      r_obs_x0     <= 10'd0;
      r_obs_y0     <= 10'd0;
      r_obs_x1     <= 10'd0;
      r_obs_y1     <= 10'd0;
      r_obs_valid  <= 1'b0;
      r_wave_count <= 8'd0;
    end else if (!enable) begin
      // Disable wins over any frame tick; positions and count are kept.
      r_state     <= c_IDLE;
      r_obs_valid <= 1'b0;
      r_gap_cnt   <= 8'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_rom_index <= w_map_idx;
          r_state     <= c_LOAD;
        end
        c_LOAD: begin
          r_obs_x0    <= bus.rom_x0;
          r_obs_y0    <= bus.rom_y0;
          r_obs_x1    <= bus.rom_x1;
          r_obs_y1    <= bus.rom_y1;
          r_obs_valid <= 1'b1;
          if (r_wave_count != 8'hFF) begin
            r_wave_count <= r_wave_count + 8'd1;
          end
          r_state <= c_RUN;
        end
        c_RUN: begin
          if (frame_tick) begin
            r_obs_y0 <= w_y0_nxt;
            r_obs_y1 <= w_y1_nxt;
            if (w_wave_done) begin
              r_state     <= c_GAP;
              r_obs_valid <= 1'b0;
              r_gap_cnt   <= 8'd0;
            end
          end
        end
        c_GAP: begin
          if (frame_tick) begin
            if (w_gap_nxt == GAP_FRAMES) begin
              r_rom_index <= w_map_idx;
              r_gap_cnt   <= 8'd0;
              r_state     <= c_LOAD;
            end else begin
              r_gap_cnt <= w_gap_nxt;
            end
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obstacle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_obstacle_sequencer
// Description : Self-checking bench for obstacle_sequencer with a wave
//               scoreboard, a stimulus table and hand-written corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obstacle_sequencer;

  typedef struct packed { logic [9:0] x0; logic [9:0] y0; logic [9:0] x1; logic [9:0] y1; } rom_t;
  typedef struct packed { logic [2:0] idx; logic [7:0] wc; } exp_t;
  typedef struct packed {
    logic       en;
    logic       tick;
    logic [3:0] spd;
    logic       exp_valid;
    logic [9:0] exp_y0;
    logic [9:0] exp_y1;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       frame_tick;
  logic [3:0] speed;
  logic       en2;
  logic       tick2;
  logic [3:0] speed2;

  int         checks   = 0;
  int         failures = 0;
  int         exp_wc   = 0;
  exp_t       sbq[$];
  logic [7:0] m_lfsr;

  obstacle_sequencer_if bus();
  obstacle_sequencer_if bus2();

  obstacle_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .frame_tick (frame_tick),
    .speed      (speed),
    .bus        (bus.master)
  );

  obstacle_sequencer #(.Y_LIMIT(10'd1), .GAP_FRAMES(8'd1)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (en2),
    .frame_tick (tick2),
    .speed      (speed2),
    .bus        (bus2.master)
  );

  always #5 clk = ~clk;

  function automatic rom_t rom(input logic [2:0] i);
    case (i)
      3'd0:    rom = {10'd10,  10'd100, 10'd50,  10'd200};
      3'd1:    rom = {10'd20,  10'd300, 10'd60,  10'd0};
      3'd2:    rom = {10'd30,  10'd479, 10'd70,  10'd479};
      3'd3:    rom = {10'd197, 10'd0,   10'd361, 10'd610};
      3'd4:    rom = {10'd40,  10'h262, 10'd80,  10'd700};
      3'd5:    rom = {10'd90,  10'd400, 10'd130, 10'd470};
      default: rom = '0;
    endcase
  endfunction

  assign {bus.rom_x0, bus.rom_y0, bus.rom_x1, bus.rom_y1}     = rom(bus.rom_index);
  assign {bus2.rom_x0, bus2.rom_y0, bus2.rom_x1, bus2.rom_y1} = rom(bus2.rom_index);

  // Reference LFSR: x^8 feedback from bits 7,5,4,3, seeded with 1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'h01;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic logic [2:0] map_idx(input logic [7:0] l);
    logic [2:0] m;
    m = l[2:0];
    if (m == 3'd6) m = 3'd0;
    else if (m == 3'd7) m = 3'd1;
    return m;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic tk, input logic [3:0] sp);
    enable     = en;
    frame_tick = tk;
    speed      = sp;
    @(negedge clk);
  endtask

  // Called on the cycle whose rising edge will select a new pattern.
  task automatic push_wave();
    exp_t e;
    if (exp_wc < 255) exp_wc++;
    e.idx = map_idx(m_lfsr);
    e.wc  = exp_wc[7:0];
    sbq.push_back(e);
  endtask

  task automatic wait_idx(input logic [2:0] want);
    int n;
    n = 0;
    while (map_idx(m_lfsr) != want && n < 300) begin
      step(1'b0, 1'b0, 4'd0);
      n++;
    end
    check("wait_index_found", int'(map_idx(m_lfsr)), int'(want));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rom_index"},  int'(bus.rom_index),  0);
    check({tag, "_obs_x0"},     int'(bus.obs_x0),     0);
    check({tag, "_obs_y0"},     int'(bus.obs_y0),     0);
    check({tag, "_obs_x1"},     int'(bus.obs_x1),     0);
    check({tag, "_obs_y1"},     int'(bus.obs_y1),     0);
    check({tag, "_obs_valid"},  int'(bus.obs_valid),  0);
    check({tag, "_wave_count"}, int'(bus.wave_count), 0);
  endtask

  // Scoreboard: each rising obs_valid must match the oldest expected wave.
  initial begin
    exp_t e;
    rom_t r;
    logic pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.obs_valid === 1'b1 && pv == 1'b0) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_wave: actual=1 expected=0");
        end else begin
          e = sbq.pop_front();
          r = rom(e.idx);
          check("sb_rom_index",  int'(bus.rom_index),  int'(e.idx));
          check("sb_obs_x0",     int'(bus.obs_x0),     int'(r.x0));
          check("sb_obs_y0",     int'(bus.obs_y0),     int'(r.y0));
          check("sb_obs_x1",     int'(bus.obs_x1),     int'(r.x1));
          check("sb_obs_y1",     int'(bus.obs_y1),     int'(r.y1));
          check("sb_wave_count", int'(bus.wave_count), int'(e.wc));
        end
      end
      pv = bus.obs_valid;
    end
  end

  initial begin
    vec_t vt[6];
    int   waves;
    int   y;
    logic pv2;

    vt[0] = {1'b1, 1'b1, 4'd0,  1'b1, 10'd0,  10'd610};
    vt[1] = {1'b1, 1'b0, 4'd9,  1'b1, 10'd0,  10'd610};
    vt[2] = {1'b1, 1'b1, 4'd15, 1'b1, 10'd15, 10'd610};
    vt[3] = {1'b1, 1'b1, 4'd1,  1'b1, 10'd16, 10'd610};
    vt[4] = {1'b1, 1'b0, 4'd3,  1'b1, 10'd16, 10'd610};
    vt[5] = {1'b1, 1'b1, 4'd8,  1'b1, 10'd24, 10'd610};

    rst_n = 1'b0; enable = 1'b0; frame_tick = 1'b0; speed = 4'd0;
    en2 = 1'b0; tick2 = 1'b0; speed2 = 4'd1;
    repeat (3) @(negedge clk);
    check_reset("reset");

    // Release reset with enable already high: pattern from LFSR seed.
    rst_n = 1'b1;
    push_wave();
    step(1'b1, 1'b0, 4'd0);
    check("load_valid_low", int'(bus.obs_valid), 0);
    check("load_rom_index", int'(bus.rom_index), int'(map_idx(8'h01)));
    step(1'b1, 1'b0, 4'd0);
    check("enable_to_valid", int'(bus.obs_valid), 1);

    // Pattern 1 (y0=300, y1=0): one tick, then disable on a tick.
    step(1'b1, 1'b1, 4'd5);
    check("run_y0_step", int'(bus.obs_y0), 305);
    check("run_y1_step", int'(bus.obs_y1), 5);
    step(1'b0, 1'b1, 4'd5);
    check("dis_valid", int'(bus.obs_valid), 0);
    check("dis_y0_hold", int'(bus.obs_y0), 305);
    check("dis_y1_hold", int'(bus.obs_y1), 5);
    check("dis_wc_hold", int'(bus.wave_count), 1);
    step(1'b0, 1'b1, 4'd7);
    check("idle_tick_y0", int'(bus.obs_y0), 305);

    // Pattern 3 at speed 4: y0 reaches the road edge on tick 120.
    wait_idx(3'd3);
    push_wave();
    step(1'b1, 1'b0, 4'd4);
    step(1'b1, 1'b0, 4'd4);
    check("p3_valid", int'(bus.obs_valid), 1);
    for (int i = 1; i <= 120; i++) begin
      step(1'b1, 1'b1, 4'd4);
      check("p3_y0", int'(bus.obs_y0), 4 * i);
      check("p3_y1_parked", int'(bus.obs_y1), 610);
      check("p3_valid_run", int'(bus.obs_valid), (i < 120) ? 1 : 0);
    end

    // Gap: 30 ticks, with an idle clk between ticks.
    for (int g = 1; g <= 30; g++) begin
      if (g == 30) push_wave();
      step(1'b1, 1'b1, 4'd4);
      check("gap_y0_hold", int'(bus.obs_y0), 480);
      check("gap_x0_hold", int'(bus.obs_x0), 197);
      check("gap_valid", int'(bus.obs_valid), 0);
      step(1'b1, 1'b0, 4'd4);
      check("gap_end_valid", int'(bus.obs_valid), (g == 30) ? 1 : 0);
    end
    step(1'b0, 1'b0, 4'd0);

    // Table-driven speeds on a pattern-3 wave; tick during LOAD ignored.
    wait_idx(3'd3);
    push_wave();
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'd15);
    check("load_ignores_tick", int'(bus.obs_y0), 0);
    for (int k = 0; k < 6; k++) begin
      step(vt[k].en, vt[k].tick, vt[k].spd);
      check("vec_valid", int'(bus.obs_valid), int'(vt[k].exp_valid));
      check("vec_y0",    int'(bus.obs_y0),    int'(vt[k].exp_y0));
      check("vec_y1",    int'(bus.obs_y1),    int'(vt[k].exp_y1));
    end
    for (int i = 1; i <= 31; i++) begin
      step(1'b1, 1'b1, 4'd15);
      y = 24 + 15 * i;
      check("fast_y0", int'(bus.obs_y0), y);
      check("fast_valid", int'(bus.obs_valid), (y < 480) ? 1 : 0);
    end
    step(1'b0, 1'b0, 4'd0);

    // Asynchronous reset in the middle of a wave at y0=100.
    wait_idx(3'd3);
    push_wave();
    step(1'b1, 1'b0, 4'd4);
    step(1'b1, 1'b0, 4'd4);
    repeat (25) step(1'b1, 1'b1, 4'd4);
    check("pre_reset_y0", int'(bus.obs_y0), 100);
    #2 rst_n = 1'b0;
    #1 check_reset("async_reset");
    exp_wc = 0;
    enable = 1'b0; frame_tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);
    check("post_reset_valid", int'(bus.obs_valid), 0);
    check("post_reset_wc", int'(bus.wave_count), 0);
    push_wave();
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd0);
    check("post_reset_wave_valid", int'(bus.obs_valid), 1);
    step(1'b0, 1'b0, 4'd0);

    // Saturation: every wave ends on its first tick and gap is one frame.
    en2 = 1'b1; tick2 = 1'b1;
    waves = 0;
    pv2 = 1'b0;
    for (int c = 0; c < 2000 && waves < 257; c++) begin
      @(negedge clk);
      if (bus2.obs_valid === 1'b1 && pv2 == 1'b0) begin
        waves++;
        if (waves >= 250) check("sat_wave_count", int'(bus2.wave_count), (waves > 255) ? 255 : waves);
      end
      pv2 = bus2.obs_valid;
    end
    check("sat_waves_seen", waves, 257);
    en2 = 1'b0; tick2 = 1'b0;

    check("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/obstacle_sequencer.md
OBSTACLE_SEQUENCER -- requirements
Module: obstacle_sequencer

Interface
REQ-001 Parameter Y_LIMIT, default 10'd480: first row below the visible road; an obstacle with y >= Y_LIMIT is inactive. Legal range is 1..1008.
REQ-002 Parameter GAP_FRAMES, default 8'd30: number of frame ticks between the end of one wave and the next spawn. Legal range is 1..255.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  level; 1 runs the sequencer, 0 returns it to IDLE.
REQ-006 frame_tick  input  1  one-clk pulse per video frame.
REQ-007 speed  input  4  pixels added to each active y per frame_tick; sampled on each tick.
REQ-008 rom_index  output  3  registered pattern select to the position ROM.
REQ-009 rom_x0, rom_y0, rom_x1, rom_y1  input  10 each  combinational ROM outputs for rom_index.
REQ-010 obs_x0, obs_y0, obs_x1, obs_y1  output  10 each  current obstacle positions.
REQ-011 obs_valid  output  1  1 while a wave is loaded and moving (RUN state).
REQ-012 wave_count  output  8  number of waves spawned; saturates at 255.

Function
REQ-013 An 8-bit LFSR shall shift left every clk: new bit0 = l[7]^l[5]^l[4]^l[3]. It runs regardless of enable.
REQ-014 The mapped index shall be l[2:0] when l[2:0] < 6; values 6 and 7 shall map to 0 and 1.
REQ-015 The FSM shall have exactly the states IDLE, LOAD, RUN and GAP.
REQ-016 IDLE with enable=1: rom_index <= mapped index; go to LOAD.
REQ-017 LOAD (one clk): obs_* <= rom_*; obs_valid <= 1; wave_count increments with saturation; go to RUN.
REQ-018 RUN on frame_tick: each obstacle with y < Y_LIMIT gets y <= y + speed, zero-extended. The x values never change.
REQ-019 RUN: an obstacle loaded with y >= Y_LIMIT (e.g. 10'h262) is inactive from the start and never moves.
REQ-020 RUN: when both obs_y0 and obs_y1 are >= Y_LIMIT after the update, go to GAP on the next clk and clear obs_valid. The gap counter loads 0.
REQ-021 GAP: the counter increments on each frame_tick. When it reaches GAP_FRAMES: rom_index <= mapped index; go to LOAD.
REQ-022 No arithmetic overflow: the adder only operates when y < Y_LIMIT <= 1008, so y + 15 <= 1022.
REQ-023 enable=0 in any state: next clk go to IDLE and set obs_valid <= 0. obs_* and wave_count hold; the gap counter clears. enable=0 takes priority over a simultaneous frame_tick.
REQ-024 frame_tick in IDLE or LOAD shall be ignored.
REQ-025 speed=0: obstacles hold position in RUN, with no timeout.
REQ-026 Latency: enable rising edge to obs_valid=1 is 2 clks. The final RUN tick to obs_valid=0 is 1 clk. The GAP_FRAMES-th tick to obs_valid=1 is 2 clks.

Reset
REQ-027 rst_n=0 shall immediately force: state IDLE, lfsr 8'h01, rom_index 3'd0, obs_x0/obs_y0/obs_x1/obs_y1 10'd0, obs_valid 0, wave_count 8'd0, gap counter 0.
REQ-028 Asserting rst_n mid-wave shall abandon the wave with no residual state. On release, the sequencer resumes from IDLE.

Verification
REQ-029 Reset release, enable=1 at clk 0 -> rom_index equals the mapped index of the reference-model LFSR at that clk. obs_* equal the ROM values and obs_valid=1 two clks later. wave_count=1.
REQ-030 Pattern index 3 (x0=197,y0=0,x1=361,y1=610), speed=4 -> obs_y0 steps 4 per tick and obs_y1 stays 610. After tick 120, obs_y0=480 and obs_valid drops next clk.
REQ-031 After the wave ends, 30 frame_ticks -> new LOAD, obs_valid=1 two clks after tick 30, wave_count=2. Ticks during the gap leave obs_* unchanged.
REQ-032 enable dropped in RUN on the same clk as frame_tick -> no y update, IDLE next clk, obs_valid=0. Re-enable -> fresh wave, wave_count increments.
REQ-033 Force 255 waves (GAP_FRAMES=1, Y_LIMIT=1, speed=1) -> wave_count holds at 255 on wave 256.
REQ-034 rst_n pulsed low mid-RUN with obs_y0=100 -> all outputs take their REQ-027 values asynchronously, with no clk edge required.
